// File: rtl/spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_responder
// Description : SPI mode-0 target oversampled in the clk domain; MOSI bytes go
//               to an RX FIFO drained by the upload handshake, MISO bytes come
//               from an FWFT TX source or a default byte.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_responder #(
    parameter int          RX_DEPTH      = 16,
    parameter logic [7:0]  DEFAULT_TX    = 8'hA5,
    parameter logic [7:0]  UPLOAD_SOURCE = 8'h14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        upload_active,
    output logic        upload_req,
    output logic [7:0]  upload_data,
    output logic [7:0]  upload_source,
    output logic        upload_valid,
    input  logic        upload_ready,
    output logic        frame_done,
    output logic [15:0] frame_byte_count,
    output logic        rx_overflow
);

    localparam int         c_aw        = $clog2(RX_DEPTH);
    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_active = 1'b1;

    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [2:0] r_cs_vld;
    logic [1:0] r_mosi_sync;

    // r_cs_vld marks stages holding real samples, so a low CS present at reset
    // release is not mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_cs_vld    <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
            r_cs_vld    <= {r_cs_vld[1:0], 1'b1};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;
    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2] & r_cs_vld[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_mosi      = r_mosi_sync[1];

    logic [0:0]  r_state;
    logic [2:0]  r_bit_cnt;
    logic [15:0] r_byte_cnt;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_rx_shift;
    logic        r_tx_from_src;
    logic        r_tx_ready;
    logic        r_frame_done;
    logic [15:0] r_frame_byte_count;

    logic       w_push_req;
    logic [7:0] w_push_data;
    assign w_push_req  = (r_state == c_st_active) && !w_cs_rise && w_sclk_rise &&
                         (r_bit_cnt == 3'd7);
    assign w_push_data = {r_rx_shift[6:0], w_mosi};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= c_st_idle;
            r_bit_cnt          <= 3'd0;
            r_byte_cnt         <= 16'd0;
            r_tx_shift         <= 8'd0;
            r_rx_shift         <= 8'd0;
            r_tx_from_src      <= 1'b0;
            r_tx_ready         <= 1'b0;
            r_frame_done       <= 1'b0;
            r_frame_byte_count <= 16'd0;
        end else begin
            r_tx_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_cs_fall) begin
                        r_state       <= c_st_active;
                        r_bit_cnt     <= 3'd0;
                        r_byte_cnt    <= 16'd0;
                        r_tx_shift    <= tx_valid ? tx_data : DEFAULT_TX;
                        r_tx_from_src <= tx_valid;
                    end
                end
                c_st_active: begin
                    if (w_cs_rise) begin
                        r_state            <= c_st_idle;
                        r_frame_done       <= 1'b1;
                        r_frame_byte_count <= r_byte_cnt;
                        r_bit_cnt          <= 3'd0;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[6:0], w_mosi};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        // Pop only after the first bit of the loaded byte is out
                        if (r_bit_cnt == 3'd0 && r_tx_from_src) begin
                            r_tx_ready    <= 1'b1;
                            r_tx_from_src <= 1'b0;
                        end
                        if (r_bit_cnt == 3'd7 && r_byte_cnt != 16'hFFFF)
                            r_byte_cnt <= r_byte_cnt + 16'd1;
                    end else if (w_sclk_fall) begin
                        if (r_bit_cnt == 3'd0) begin
                            r_tx_shift    <= tx_valid ? tx_data : DEFAULT_TX;
                            r_tx_from_src <= tx_valid;
                        end else begin
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    logic [7:0]    r_mem [RX_DEPTH];
    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    logic          r_overflow;
    logic          w_empty, w_full, w_pop, w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_pop   = !w_empty && upload_ready;
    assign w_push  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < RX_DEPTH; i++) r_mem[i] <= 8'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= w_push_data;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_req && !w_push) r_overflow <= 1'b1;
        end
    end

    assign spi_miso         = (r_state == c_st_active) ? r_tx_shift[7] : 1'b1;
    assign tx_ready         = r_tx_ready;
    assign upload_valid     = !w_empty;
    assign upload_active    = !w_empty;
    assign upload_req       = !w_empty;
    assign upload_data      = r_mem[r_rd_ptr[c_aw-1:0]];
    assign upload_source    = UPLOAD_SOURCE;
    assign frame_done       = r_frame_done;
    assign frame_byte_count = r_frame_byte_count;
    assign rx_overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_responder
// Description : Directed self-checking bench for spi_slave_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk, spi_cs_n, spi_mosi, spi_miso;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic        upload_active, upload_req, upload_valid, upload_ready;
    logic [7:0]  upload_data, upload_source;
    logic        frame_done, rx_overflow;
    logic [15:0] frame_byte_count;

    spi_slave_responder dut (
        .clk              (clk),
        .rst              (rst),
        .spi_clk          (spi_clk),
        .spi_cs_n         (spi_cs_n),
        .spi_mosi         (spi_mosi),
        .spi_miso         (spi_miso),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .upload_active    (upload_active),
        .upload_req       (upload_req),
        .upload_data      (upload_data),
        .upload_source    (upload_source),
        .upload_valid     (upload_valid),
        .upload_ready     (upload_ready),
        .frame_done       (frame_done),
        .frame_byte_count (frame_byte_count),
        .rx_overflow      (rx_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // TX byte source: initial block owns contents/base/len, monitor owns pops
    logic [7:0] tx_src [0:1];
    int tx_base = 0, tx_len = 0, tx_pops = 0, tx_idx;
    always_comb tx_idx = tx_pops - tx_base;
    assign tx_valid = (tx_idx < tx_len);
    assign tx_data  = tx_src[tx_idx[0]];

    logic [7:0] up_mem [0:63];
    int up_cnt = 0, fd_cnt = 0;
    always @(posedge clk) begin
        if (tx_ready) tx_pops <= tx_pops + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (!rst && upload_valid && upload_ready) begin
            up_mem[up_cnt[5:0]] <= upload_data;
            up_cnt <= up_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        half();
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Mode 0: master drives MOSI while SCLK low, samples MISO on the rise
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = mo[7-b];
            half();
            mi = {mi[6:0], spi_miso};
            spi_clk = 1'b1;
            half();
            spi_clk = 1'b0;
        end
    endtask

    initial begin
        #1ms;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] rd0, rd1, dummy;
    int pops0, up0, fd0;

    initial begin
        rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; upload_ready = 1'b1;
        tx_src[0] = 8'h00; tx_src[1] = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'd1);
        check("rst_upload_valid", 32'(upload_valid), 32'd0);
        check("rst_upload_active", 32'(upload_active), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_overflow", 32'(rx_overflow), 32'd0);
        check("rst_frame_count", 32'(frame_byte_count), 32'd0);
        check("rst_upload_data", 32'(upload_data), 32'd0);

        // Two-byte frame fed from the TX source
        tx_src[0] = 8'h5A; tx_src[1] = 8'hC3; tx_base = tx_pops; tx_len = 2;
        pops0 = tx_pops; up0 = up_cnt; fd0 = fd_cnt;
        cs_low();
        xfer(8'hAA, 8, rd0);
        xfer(8'hBB, 8, rd1);
        cs_high();
        check("f1_miso_b0", 32'(rd0), 32'h5A);
        check("f1_miso_b1", 32'(rd1), 32'hC3);
        check("f1_tx_pops", 32'(tx_pops - pops0), 32'd2);
        check("f1_uploads", 32'(up_cnt - up0), 32'd2);
        check("f1_up0", 32'(up_mem[up0]), 32'hAA);
        check("f1_up1", 32'(up_mem[up0+1]), 32'hBB);
        check("f1_source", 32'(upload_source), 32'h14);
        check("f1_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check("f1_count", 32'(frame_byte_count), 32'd2);

        // Empty TX source: default byte, no pops
        tx_base = tx_pops; tx_len = 0;
        pops0 = tx_pops; up0 = up_cnt;
        cs_low();
        xfer(8'hCC, 8, rd0);
        cs_high();
        check("f2_miso_default", 32'(rd0), 32'hA5);
        check("f2_tx_pops", 32'(tx_pops - pops0), 32'd0);
        check("f2_uploads", 32'(up_cnt - up0), 32'd1);
        check("f2_up0", 32'(up_mem[up0]), 32'hCC);
        check("f2_count", 32'(frame_byte_count), 32'd1);

        // Partial byte discarded, then a complete one
        up0 = up_cnt; fd0 = fd_cnt;
        cs_low();
        xfer(8'h3C, 5, dummy);
        cs_high();
        check("f3_uploads", 32'(up_cnt - up0), 32'd0);
        check("f3_count", 32'(frame_byte_count), 32'd0);
        check("f3_frame_done", 32'(fd_cnt - fd0), 32'd1);
        cs_low();
        xfer(8'h3C, 8, dummy);
        cs_high();
        check("f4_uploads", 32'(up_cnt - up0), 32'd1);
        check("f4_up0", 32'(up_mem[up0]), 32'h3C);
        check("f4_count", 32'(frame_byte_count), 32'd1);

        // Overflow: 17 bytes into a 16-deep FIFO with the consumer stalled
        upload_ready = 1'b0;
        up0 = up_cnt;
        cs_low();
        for (int i = 0; i <= 16; i++) xfer(8'(i), 8, dummy);
        cs_high();
        check("f5_overflow", 32'(rx_overflow), 32'd1);
        check("f5_count", 32'(frame_byte_count), 32'd17);
        check("f5_valid_held", 32'(upload_valid), 32'd1);
        check("f5_head", 32'(upload_data), 32'h00);
        upload_ready = 1'b1;
        repeat (30) @(negedge clk);
        check("f5_uploads", 32'(up_cnt - up0), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("f5_up%0d", i), 32'(up_mem[up0+i]), 32'(i));
        check("f5_drained", 32'(upload_valid), 32'd0);

        // Reset mid-frame with CS held low
        up0 = up_cnt; fd0 = fd_cnt;
        cs_low();
        xfer(8'hFF, 3, dummy);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tx_src[0] = 8'h3E; tx_base = tx_pops; tx_len = 1;
        pops0 = tx_pops;
        xfer(8'hFF, 5, dummy);
        xfer(8'h55, 8, dummy);
        cs_high();
        check("f6_overflow_cleared", 32'(rx_overflow), 32'd0);
        check("f6_uploads", 32'(up_cnt - up0), 32'd0);
        check("f6_tx_pops", 32'(tx_pops - pops0), 32'd0);
        check("f6_frame_done", 32'(fd_cnt - fd0), 32'd0);
        check("f6_count", 32'(frame_byte_count), 32'd0);
        cs_low();
        xfer(8'h81, 8, rd0);
        cs_high();
        check("f7_uploads", 32'(up_cnt - up0), 32'd1);
        check("f7_up0", 32'(up_mem[up0]), 32'h81);
        check("f7_miso", 32'(rd0), 32'h3E);
        check("f7_tx_pops", 32'(tx_pops - pops0), 32'd1);
        check("f7_count", 32'(frame_byte_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
